// File: rtl/alu_seq_nbits.sv
// Sequential ALU: single-cycle logic/arithmetic ops and an optional iterative multiplier.
// Define ALU_SEQ_MUL_EN to build the shift-add multiplier for op 110; otherwise op 110 flags err.
//
// state | meaning
// IDLE  | waiting for start, outputs hold
// EXEC  | one-cycle ALU operation, result written on leaving
// MUL   | shift-add multiply, one step per clock (ALU_SEQ_MUL_EN only)
module alu_seq_nbits #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 zero,
  output logic                 err,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   alu_sum;
  logic             alu_err;

`ifdef ALU_SEQ_MUL_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   mplier;

  assign prod_nxt = mplier[0] ? (prod + mcand) : prod;
`endif

  // bit WIDTH carries the carry-out / borrow; logic ops leave it 0
  always_comb begin
    alu_sum = '0;
    alu_err = 1'b0;
    case (op_q)
      3'b000: alu_sum = {1'b0, a_q} + {1'b0, b_q};
      3'b001: alu_sum = {1'b0, a_q} - {1'b0, b_q};
      3'b010: alu_sum = {1'b0, a_q & b_q};
      3'b011: alu_sum = {1'b0, a_q | b_q};
      3'b100: alu_sum = {1'b0, a_q ^ b_q};
      3'b101: alu_sum = {1'b0, ~a_q};
      3'b110: begin
`ifndef ALU_SEQ_MUL_EN
        alu_err = 1'b1;
`endif
      end
      3'b111: alu_sum = {1'b0, result[WIDTH-1:0]} + {1'b0, a_q};
      default: alu_sum = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            busy <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
            if (op == 3'b110) begin
              state  <= MUL;
              cnt    <= CNT_W'(WIDTH);
              prod   <= '0;
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
            end else begin
              state <= EXEC;
            end
`else
            state <= EXEC;
`endif
          end
        end
        EXEC: begin
          result <= {{WIDTH{1'b0}}, alu_sum[WIDTH-1:0]};
          carry  <= alu_sum[WIDTH];
          zero   <= (alu_sum[WIDTH-1:0] == '0);
          err    <= alu_err;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          // last step: commit the product straight from the adder
          if (cnt == CNT_W'(1)) begin
            result <= prod_nxt;
            carry  <= |prod_nxt[2*WIDTH-1:WIDTH];
            zero   <= (prod_nxt == '0);
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_nbits.sv
// Scoreboard bench for alu_seq_nbits (WIDTH=8); follows ALU_SEQ_MUL_EN to pick the op 110 checks.
module tb_alu_seq_nbits;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic [15:0] result;
  logic        carry, zero, err, busy, done;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc;

  alu_seq_nbits #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .result(result), .carry(carry), .zero(zero), .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_result"}, {16'h0, result}, {16'h0, e.res});
        check({e.name, "_carry"}, {31'h0, carry}, {31'h0, e.c});
        check({e.name, "_zero"}, {31'h0, zero}, {31'h0, e.z});
        check({e.name, "_err"}, {31'h0, err}, {31'h0, e.e});
      end
    end
  end

  // call just after a negedge; returns at the negedge following the accepting edge
  task automatic send(input string name, input logic [2:0] o, input logic [7:0] va,
                      input logic [7:0] vb, input logic [15:0] r, input logic c,
                      input logic z, input logic e);
    exp_t x;
    x.name = name; x.res = r; x.c = c; x.z = z; x.e = e;
    exp_q.push_back(x);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // counts negedges with busy high until done shows, bounded
  task automatic wait_done(input string name, output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) n++;
      @(negedge clk);
    end
    if (done !== 1'b1) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_result"}, {16'h0, result}, 32'h0);
    check({name, "_flags"}, {27'h0, carry, zero, err, busy, done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ACC back-to-back, second start issued in the done cycle
    send("acc1", 3'b111, 8'h80, 8'h55, 16'h0080, 1'b0, 1'b0, 1'b0);
    wait_done("acc1", cyc);
    send("acc2", 3'b111, 8'h80, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0);
    wait_done("acc2", cyc);
    @(negedge clk);

    send("add_ff_01", 3'b000, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b1, 1'b0);
    wait_done("add_ff_01", cyc);
    check("add_busy_cycles", cyc, 32'd1);
    check("add_done_busy_low", {31'h0, busy}, 32'h0);
    @(negedge clk);
    check("done_one_cycle", {31'h0, done}, 32'h0);

    send("sub_03_05", 3'b001, 8'h03, 8'h05, 16'h00FE, 1'b1, 1'b0, 1'b0);
    wait_done("sub_03_05", cyc);
    repeat (3) @(negedge clk);
    check("hold_result", {16'h0, result}, 32'h00FE);
    check("hold_carry", {31'h0, carry}, 32'h1);

    send("and", 3'b010, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1'b0);
    wait_done("and", cyc);
    @(negedge clk);
    send("xor", 3'b100, 8'hAA, 8'hFF, 16'h0055, 1'b0, 1'b0, 1'b0);
    wait_done("xor", cyc);
    @(negedge clk);
    send("not_a", 3'b101, 8'h0F, 8'h99, 16'h00F0, 1'b0, 1'b0, 1'b0);
    wait_done("not_a", cyc);
    @(negedge clk);

`ifdef ALU_SEQ_MUL_EN
    send("mul_ff_ff", 3'b110, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0, 1'b0);
    start = 1'b1; op = 3'b000; a = 8'h01; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    wait_done("mul_ff_ff", cyc);
    check("mul_busy_cycles", cyc + 1, 32'd8);
    repeat (3) @(negedge clk);
    send("mul_0f_03", 3'b110, 8'h0F, 8'h03, 16'h002D, 1'b0, 1'b0, 1'b0);
    wait_done("mul_0f_03", cyc);
    @(negedge clk);
    // reset during the third multiply cycle
    send("mul_abort", 3'b110, 8'h03, 8'h03, 16'h0009, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
`else
    send("mul_disabled", 3'b110, 8'h02, 8'h03, 16'h0000, 1'b0, 1'b1, 1'b1);
    wait_done("mul_disabled", cyc);
    check("mul_disabled_busy_cycles", cyc, 32'd1);
    @(negedge clk);
    send("add_clears_err", 3'b000, 8'h02, 8'h03, 16'h0005, 1'b0, 1'b0, 1'b0);
    wait_done("add_clears_err", cyc);
    @(negedge clk);
    // reset while an operation is in flight
    send("add_abort", 3'b000, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 1'b0);
`endif
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("abort_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_done_result", {16'h0, result}, 32'h0);

    send("or_after_reset", 3'b011, 8'h0F, 8'hF0, 16'h00FF, 1'b0, 1'b0, 1'b0);
    wait_done("or_after_reset", cyc);
    repeat (5) @(negedge clk);
    check("pending_expectations", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq_nbits.md
ALU_SEQ_NBITS -- requirements
Module: alu_seq_nbits

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand width in bits (legal range 2..16).
REQ-002 SHALL provide port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port start  input  1  request; accepted only when busy=0.
REQ-005 SHALL provide port op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 MUL, 111 ACC.
REQ-006 SHALL provide port a  input  WIDTH  operand A.
REQ-007 SHALL provide port b  input  WIDTH  operand B.
REQ-008 SHALL provide port result  output  2*WIDTH  registered result.
REQ-009 SHALL provide port carry  output  1  registered carry/borrow/overflow flag.
REQ-010 SHALL provide port zero  output  1  registered flag, 1 when result==0 over all 2*WIDTH bits.
REQ-011 SHALL provide port err  output  1  registered illegal-operation flag.
REQ-012 SHALL provide port busy  output  1  high from accept until result write.
REQ-013 SHALL provide port done  output  1  one-cycle pulse after each result write.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, MUL; busy=1 exactly in EXEC and MUL.
REQ-015 In IDLE, start=1 at edge k SHALL latch op/a/b and go to EXEC (op!=110, or 110 without multiplier) or MUL with step counter=WIDTH.
REQ-016 EXEC SHALL write result/flags at edge k+1, pulse done for the cycle after k+1, return to IDLE.
REQ-017 MUL SHALL perform one shift-add step per edge, writing the unsigned 2*WIDTH product at edge k+WIDTH, then pulse done and return to IDLE.
REQ-018 start while busy=1 SHALL be ignored with no effect on latched operands or state.
REQ-019 start during the done cycle SHALL be accepted (state is IDLE).
REQ-020 Non-MUL results SHALL occupy result[WIDTH-1:0] with result[2*WIDTH-1:WIDTH]=0.
REQ-021 ADD: carry=carry-out of a+b; SUB: result=a-b mod 2^WIDTH, carry=1 iff a<b unsigned.
REQ-022 AND/OR/XOR/NOT A: carry=0.
REQ-023 ACC: result[WIDTH-1:0]=previous result[WIDTH-1:0]+a, carry=carry-out; b ignored.
REQ-024 MUL: carry=1 iff result[2*WIDTH-1:WIDTH]!=0.
REQ-025 err SHALL be 0 after every legal operation; result/flags/err SHALL hold between writes.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE and result=0, carry=0, zero=0, err=0, busy=0, done=0, counter=0.
REQ-027 Reset mid-operation SHALL abort it with no done pulse; first edge after release SHALL accept start normally.

Configuration
REQ-028 Macro ALU_SEQ_MUL_EN defined: op 110 SHALL execute the iterative multiplier per REQ-017/REQ-024.
REQ-029 Macro ALU_SEQ_MUL_EN undefined: no multiplier logic; op 110 SHALL take the EXEC path, write result=0, carry=0, zero=1, err=1, and pulse done at the same latency as other ops.

Verification (WIDTH=8)
REQ-030 ADD a=0xFF b=0x01 -> result 0x0000, carry=1, zero=1, busy one cycle, done one cycle after edge k+1.
REQ-031 SUB a=0x03 b=0x05 -> result 0x00FE, carry=1, zero=0, err=0.
REQ-032 With ALU_SEQ_MUL_EN, MUL a=0xFF b=0xFF, start re-pulsed with op=ADD during busy -> result 0xFE01 at edge k+8, carry=1, busy 8 cycles, second start ignored.
REQ-033 After reset, ACC a=0x80 back-to-back (second start during done) -> 0x0080 carry=0, then 0x0000 carry=1 zero=1.
REQ-034 rst_n low during 3rd MUL cycle -> all outputs 0 immediately, no done; subsequent OR a=0x0F b=0xF0 -> 0x00FF.
REQ-035 Without ALU_SEQ_MUL_EN, op=110 a=0x02 b=0x03 -> result 0x0000, err=1, zero=1, done after edge k+1; next ADD clears err.
